// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RF write port between ALU (A) and load (B).
// Registers the winner with 1-cycle latency and tracks in-flight regs.
module rf_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int FAIR     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_reg,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_reg,
  input  logic [DATA_W-1:0]   b_data,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] pending
);

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  logic              rr_ptr;
  logic              we_q;
  logic              go;
  logic              pick_b;
  logic              grant;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Pick which side wins if it is requesting; B by default on a tie
  // unless round-robin says A.
  always_comb begin
    pick_b = 1'b0;
    unique case (1'b1)
      (!a_valid):
        pick_b = 1'b1;
      (a_valid && !b_valid):
        pick_b = 1'b0;
      (a_valid && b_valid):
        pick_b = (FAIR != 0) ? (rr_ptr == SIDE_B) : 1'b1;
    endcase
  end

  // Readys depend only on valid, stall, reset and rr_ptr.
  always_comb begin
    go       = !reset && !stall;
    a_ready  = go && a_valid && !pick_b;
    b_ready  = go && b_valid && pick_b;
    grant    = a_ready || b_ready;
    sel_reg  = pick_b ? b_reg : a_reg;
    sel_data = pick_b ? b_data : a_data;
  end

  // Set bit on acceptance, clear bit of the write now on the RF port.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (grant)
      set_mask[sel_reg] = 1'b1;
    if (we_q)
      clr_mask[rf_waddr] = 1'b1;
  end

  // Output stage, round-robin pointer and pending mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pending  <= '0;
      rr_ptr   <= SIDE_A;
    end else begin
      we_q    <= grant;
      pending <= (pending & ~clr_mask) | set_mask;
      if (grant) begin
        rf_waddr <= sel_reg;
        rf_wdata <= sel_data;
        if (FAIR != 0)
          rr_ptr <= pick_b ? SIDE_A : SIDE_B;
      end
    end
  end

  // Nothing reaches the RF while reset is held.
  assign rf_we = we_q && !reset;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and random checks of rf_wb_arbiter,
// round-robin (index 0) and fixed-priority (index 1) builds side by side.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        a_valid;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic        b_valid;
  logic [3:0]  b_reg;
  logic [15:0] b_data;

  logic        a_rdy [2];
  logic        b_rdy [2];
  logic        we    [2];
  logic [3:0]  wa    [2];
  logic [15:0] wd    [2];
  logic [15:0] pend  [2];

  int checks;
  int failures;

  // reference model state, per build
  logic        m_we   [2];
  logic [3:0]  m_addr [2];
  logic [15:0] m_data [2];
  logic        tie_b  [2];

  rf_wb_arbiter #(.FAIR(1)) u_fair (
    .clk(clk), .reset(reset), .stall(stall),
    .a_valid(a_valid), .a_ready(a_rdy[0]),
    .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_rdy[0]),
    .b_reg(b_reg), .b_data(b_data),
    .rf_we(we[0]), .rf_waddr(wa[0]),
    .rf_wdata(wd[0]), .pending(pend[0])
  );

  rf_wb_arbiter #(.FAIR(0)) u_fix (
    .clk(clk), .reset(reset), .stall(stall),
    .a_valid(a_valid), .a_ready(a_rdy[1]),
    .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_rdy[1]),
    .b_reg(b_reg), .b_data(b_data),
    .rf_we(we[1]), .rf_waddr(wa[1]),
    .rf_wdata(wd[1]), .pending(pend[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner from the rules: {b, a}.
  function automatic logic [1:0] grant_of(int d);
    if (reset || stall) return 2'b00;
    if (a_valid && !b_valid) return 2'b01;
    if (b_valid && !a_valid) return 2'b10;
    if (!a_valid) return 2'b00;
    if (d == 1) return 2'b10;
    return tie_b[d] ? 2'b10 : 2'b01;
  endfunction

  // Model: the accepted write shows up one cycle later.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_we[d]   <= 1'b0;
        m_addr[d] <= 4'd0;
        m_data[d] <= 16'd0;
        tie_b[d]  <= 1'b0;
      end else if (grant_of(d) == 2'b01) begin
        m_we[d]   <= 1'b1;
        m_addr[d] <= a_reg;
        m_data[d] <= a_data;
        tie_b[d]  <= 1'b1;
      end else if (grant_of(d) == 2'b10) begin
        m_we[d]   <= 1'b1;
        m_addr[d] <= b_reg;
        m_data[d] <= b_data;
        tie_b[d]  <= 1'b0;
      end else begin
        m_we[d] <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (a_rdy[d] !== 1'b0 || b_rdy[d] !== 1'b0) begin
          failures++;
          $display("FAIL reset_ready d%0d got a=%b b=%b exp 0 0",
                   d, a_rdy[d], b_rdy[d]);
        end
        checks++;
        if (we[d] !== 1'b0) begin
          failures++;
          $display("FAIL reset_we d%0d got %b exp 0", d, we[d]);
        end
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d] !== 16'h0) begin
        failures++;
        $display("FAIL reset_pend d%0d got %h exp 0000", d, pend[d]);
      end
    end
    reset = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_a_only();
    do_reset();
    a_valid = 1'b1;
    a_reg = 4'd3;
    a_data = 16'h1234;
    b_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (a_rdy[d] !== 1'b1 || b_rdy[d] !== 1'b0) begin
        failures++;
        $display("FAIL aonly_ready d%0d got a=%b b=%b exp 1 0",
                 d, a_rdy[d], b_rdy[d]);
      end
    end
    @(negedge clk);
    a_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (we[d] !== 1'b1 || wa[d] !== 4'd3 || wd[d] !== 16'h1234) begin
        failures++;
        $display("FAIL aonly_out d%0d got we=%b a=%0d d=%h exp 1 3 1234",
                 d, we[d], wa[d], wd[d]);
      end
      checks++;
      if (pend[d] !== 16'h0008) begin
        failures++;
        $display("FAIL aonly_pend d%0d got %h exp 0008", d, pend[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (we[d] !== 1'b0 || pend[d] !== 16'h0 || wa[d] !== 4'd3) begin
        failures++;
        $display("FAIL aonly_after d%0d got we=%b p=%h a=%0d exp 0 0000 3",
                 d, we[d], pend[d], wa[d]);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    a_valid = 1'b1;
    a_reg = 4'd1;
    a_data = 16'hAAAA;
    b_valid = 1'b1;
    b_reg = 4'd2;
    b_data = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (a_rdy[0] !== (i % 2 == 0) || b_rdy[0] !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL rr_ready cyc%0d got a=%b b=%b", i, a_rdy[0], b_rdy[0]);
      end
      @(negedge clk);
      checks++;
      if (we[0] !== 1'b1 || wa[0] !== ((i % 2 == 1) ? 4'd2 : 4'd1) ||
          wd[0] !== ((i % 2 == 1) ? 16'hBBBB : 16'hAAAA)) begin
        failures++;
        $display("FAIL rr_out cyc%0d got we=%b a=%0d d=%h",
                 i, we[0], wa[0], wd[0]);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    a_valid = 1'b1;
    a_reg = 4'd1;
    a_data = 16'hAAAA;
    b_valid = 1'b1;
    b_reg = 4'd2;
    b_data = 16'hBBBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (a_rdy[1] !== 1'b0 || b_rdy[1] !== 1'b1) begin
        failures++;
        $display("FAIL fix_ready cyc%0d got a=%b b=%b exp 0 1",
                 i, a_rdy[1], b_rdy[1]);
      end
      @(negedge clk);
      checks++;
      if (we[1] !== 1'b1 || wa[1] !== 4'd2 || wd[1] !== 16'hBBBB) begin
        failures++;
        $display("FAIL fix_out cyc%0d got we=%b a=%0d d=%h exp 1 2 bbbb",
                 i, we[1], wa[1], wd[1]);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    a_valid = 1'b1;
    a_reg = 4'd7;
    a_data = 16'h0777;
    #1;
    checks++;
    if (a_rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL stall_pre got a=%b exp 1", a_rdy[0]);
    end
    @(negedge clk);
    stall = 1'b1;
    a_reg = 4'd9;
    a_data = 16'h0999;
    b_valid = 1'b1;
    b_reg = 4'd8;
    b_data = 16'h0888;
    for (int i = 0; i < 2; i++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (a_rdy[d] !== 1'b0 || b_rdy[d] !== 1'b0) begin
          failures++;
          $display("FAIL stall_ready d%0d cyc%0d got a=%b b=%b exp 0 0",
                   d, i, a_rdy[d], b_rdy[d]);
        end
      end
      checks++;
      if (we[0] !== (i == 0) || (i == 0 && wa[0] !== 4'd7)) begin
        failures++;
        $display("FAIL stall_out cyc%0d got we=%b a=%0d", i, we[0], wa[0]);
      end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    checks++;
    if (a_rdy[0] !== 1'b0 || b_rdy[0] !== 1'b1 || b_rdy[1] !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got a=%b b=%b fixb=%b exp 0 1 1",
               a_rdy[0], b_rdy[0], b_rdy[1]);
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    checks++;
    if (we[0] !== 1'b1 || wa[0] !== 4'd8 || wd[0] !== 16'h0888) begin
      failures++;
      $display("FAIL stall_commit got we=%b a=%0d d=%h exp 1 8 0888",
               we[0], wa[0], wd[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_valid = 1'b1;
    a_reg = 4'd5;
    a_data = 16'h0055;
    #1;
    checks++;
    if (a_rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL rmid_accept got %b exp 1", a_rdy[0]);
    end
    @(negedge clk);
    a_valid = 1'b0;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (we[d] !== 1'b0) begin
        failures++;
        $display("FAIL rmid_we d%0d got %b exp 0", d, we[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (we[d] !== 1'b0 || pend[d] !== 16'h0) begin
        failures++;
        $display("FAIL rmid_after d%0d got we=%b p=%h exp 0 0000",
                 d, we[d], pend[d]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (we[0] !== 1'b0 || we[1] !== 1'b0) begin
      failures++;
      $display("FAIL rmid_late got %b %b exp 0 0", we[0], we[1]);
    end
  endtask

  task automatic test_random();
    logic [1:0]  g;
    logic [15:0] ep;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 4) == 0);
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      a_reg = 4'($urandom_range(0, 3));
      b_reg = 4'($urandom_range(0, 3));
      a_data = 16'($urandom);
      b_data = 16'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        g = grant_of(d);
        checks++;
        if (a_rdy[d] !== g[0] || b_rdy[d] !== g[1]) begin
          failures++;
          $display("FAIL rnd_ready d%0d c%0d got a=%b b=%b exp %b %b",
                   d, c, a_rdy[d], b_rdy[d], g[0], g[1]);
        end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ep = m_we[d] ? (16'h1 << m_addr[d]) : 16'h0;
        checks++;
        if (we[d] !== (m_we[d] && !reset) || wa[d] !== m_addr[d] ||
            wd[d] !== m_data[d] || pend[d] !== ep) begin
          failures++;
          $display("FAIL rnd_out d%0d c%0d got %b %0d %h %h exp %b %0d %h %h",
                   d, c, we[d], wa[d], wd[d], pend[d],
                   m_we[d] && !reset, m_addr[d], m_data[d], ep);
        end
      end
    end
    reset = 1'b0;
    stall = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    stall = 1'b0;
    a_valid = 1'b0;
    a_reg = 4'd0;
    a_data = 16'd0;
    b_valid = 1'b0;
    b_reg = 4'd0;
    b_data = 16'd0;
    test_reset();
    test_a_only();
    test_round_robin();
    test_fixed_priority();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
